// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA timing generator and framebuffer address sequencer for one pixel
//   clock domain. Stage 1 registers the framebuffer read strobe/address from
//   the raw h/v counters; the video outputs follow RD_LAT further enabled
//   stages so that synchronous BRAM read data lines up with de.
// Ports
//   clk, rst_n (synchronous, active-low), pix_ce (pixel clock enable)
//   hsync, vsync, de, x, y, line_start, frame_start : video timing outputs
//   fb_rd_en, fb_addr                                : framebuffer read port
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter int unsigned HS_POL    = 1,
  parameter int unsigned VS_POL    = 1,
  parameter int unsigned H_SHIFT   = 1,
  parameter int unsigned V_SHIFT   = 2,
  parameter int unsigned FB_STRIDE = 512,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [10:0]       x,
  output logic [10:0]       y,
  output logic              line_start,
  output logic              frame_start,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS_C   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE_C   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS_C   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE_C   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST_C = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_MASK_C = 11'((1 << V_SHIFT) - 1);

  localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(FB_STRIDE);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // Parameter legality, checked at elaboration
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL >= 2048 || V_TOTAL >= 2048 || RD_LAT > 4) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
  } vid_t;

  localparam vid_t VID_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, de: 1'b0, x: 11'd0, y: 11'd0,
                                ls: 1'b0, fs: 1'b0};

  logic [10:0]       hc_q, hc_d;
  logic [10:0]       vc_q, vc_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  vid_t              pipe_q [RD_LAT+1];
  vid_t              pipe_d [RD_LAT+1];

  logic        h_wrap, v_wrap, act, hs_a, vs_a;
  logic [10:0] vc_inc;

  // Position decode from the raw counters
  assign h_wrap = (hc_q == H_LAST_C);
  assign v_wrap = (vc_q == V_LAST_C);
  assign vc_inc = vc_q + 11'd1;
  assign act    = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
  assign hs_a   = (hc_q >= H_SS_C) && (hc_q < H_SE_C);
  assign vs_a   = (vc_q >= V_SS_C) && (vc_q < V_SE_C);

  // Counters and fb row base; row base steps once per replicated fb row
  always_comb begin : p_count
    hc_d       = hc_q;
    vc_d       = vc_q;
    row_base_d = row_base_q;
    if (pix_ce) begin
      if (h_wrap) begin
        hc_d = 11'd0;
        if (v_wrap) begin
          vc_d       = 11'd0;
          row_base_d = '0;
        end else begin
          vc_d = vc_inc;
          if ((vc_inc < V_ACT_C) && ((vc_inc & V_MASK_C) == 11'd0)) begin
            row_base_d = row_base_q + STRIDE_C;
          end
        end
      end else begin
        hc_d = hc_q + 11'd1;
      end
    end
  end

  // Stage 1 (read port + video decode) and the RD_LAT video delay line
  always_comb begin : p_pipe
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    pipe_d  = pipe_q;
    if (pix_ce) begin
      rd_en_d = act;
      if (act) begin
        addr_d = row_base_q + ADDR_W'(hc_q >> H_SHIFT);
      end
      pipe_d[0] = '{hs: hs_a ? HS_ON : ~HS_ON,
                    vs: vs_a ? VS_ON : ~VS_ON,
                    de: act,
                    x:  act ? hc_q : 11'd0,
                    y:  act ? vc_q : 11'd0,
                    ls: (hc_q == 11'd0),
                    fs: (hc_q == 11'd0) && (vc_q == 11'd0)};
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin : p_regs
    if (!rst_n) begin
      hc_q       <= 11'd0;
      vc_q       <= 11'd0;
      row_base_q <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        pipe_q[i] <= VID_IDLE;
      end
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      row_base_q <= row_base_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign hsync       = pipe_q[RD_LAT].hs;
  assign vsync       = pipe_q[RD_LAT].vs;
  assign de          = pipe_q[RD_LAT].de;
  assign x           = pipe_q[RD_LAT].x;
  assign y           = pipe_q[RD_LAT].y;
  assign line_start  = pipe_q[RD_LAT].ls;
  assign frame_start = pipe_q[RD_LAT].fs;
  assign fb_rd_en    = rd_en_q;
  assign fb_addr     = addr_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two small-mode instances driven from one clock/enable/reset. The reference
//   model tracks only the number of enabled cycles since reset and derives
//   every output from that count with division/modulo arithmetic.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    int hpol, vpol, hsh, vsh, stride, aw, lat;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b1;

  always #5 clk = ~clk;

  logic        hsync_a, vsync_a, de_a, ls_a, fs_a, rd_a;
  logic [10:0] x_a, y_a;
  logic [2:0]  addr_a;
  logic        hsync_b, vsync_b, de_b, ls_b, fs_b, rd_b;
  logic [10:0] x_b, y_b;
  logic [6:0]  addr_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(1), .H_SHIFT(1), .V_SHIFT(1),
    .FB_STRIDE(5), .ADDR_W(3), .RD_LAT(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a), .fb_rd_en(rd_a), .fb_addr(addr_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1), .VS_POL(0), .H_SHIFT(0), .V_SHIFT(0),
    .FB_STRIDE(20), .ADDR_W(7), .RD_LAT(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .fb_rd_en(rd_b), .fb_addr(addr_b)
  );

  logic [35:0] got_a, got_b, exp_a, exp_b;
  assign got_a = {hsync_a, vsync_a, de_a, x_a, y_a, ls_a, fs_a, rd_a, 8'(addr_a)};
  assign got_b = {hsync_b, vsync_b, de_b, x_b, y_b, ls_b, fs_b, rd_b, 8'(addr_b)};

  cfg_t   ca, cb;
  longint n_a, n_b;
  int     last_a, last_b;
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;

  // Raster position of the p-th enabled cycle after reset
  function automatic void m_pos(input cfg_t c, input longint p, output int hc, output int vc);
    longint ht, vt;
    ht = longint'(c.ha + c.hf + c.hs + c.hb);
    vt = longint'(c.va + c.vf + c.vs + c.vb);
    hc = int'(p % ht);
    vc = int'((p / ht) % vt);
  endfunction

  function automatic bit m_act(input cfg_t c, input longint p);
    int hc, vc;
    m_pos(c, p, hc, vc);
    return (hc < c.ha) && (vc < c.va);
  endfunction

  function automatic int m_addr(input cfg_t c, input longint p);
    int hc, vc;
    m_pos(c, p, hc, vc);
    return ((vc >> c.vsh) * c.stride + (hc >> c.hsh)) % (1 << c.aw);
  endfunction

  // Expected outputs after n enabled cycles since reset
  function automatic logic [35:0] m_out(input cfg_t c, input longint n, input int last);
    int hc, vc;
    logic hs, vs, dv, ls, fs, rd;
    logic [10:0] xx, yy;
    hs = (c.hpol == 0); vs = (c.vpol == 0);
    dv = 1'b0; ls = 1'b0; fs = 1'b0; xx = 11'd0; yy = 11'd0; rd = 1'b0;
    if (n - 1 - longint'(c.lat) >= 0) begin
      m_pos(c, n - 1 - longint'(c.lat), hc, vc);
      dv = (hc < c.ha) && (vc < c.va);
      hs = ((hc >= c.ha + c.hf) && (hc < c.ha + c.hf + c.hs)) ? (c.hpol != 0) : (c.hpol == 0);
      vs = ((vc >= c.va + c.vf) && (vc < c.va + c.vf + c.vs)) ? (c.vpol != 0) : (c.vpol == 0);
      xx = dv ? 11'(hc) : 11'd0;
      yy = dv ? 11'(vc) : 11'd0;
      ls = (hc == 0);
      fs = (hc == 0) && (vc == 0);
    end
    if (n >= 1) rd = m_act(c, n - 1);
    return {hs, vs, dv, xx, yy, ls, fs, rd, 8'(last)};
  endfunction

  // One clock: drive inputs away from the edge, advance the model, sample
  task automatic step(input bit ce, input bit rst);
    @(negedge clk);
    pix_ce = ce;
    rst_n  = ~rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      n_a = 0; n_b = 0; last_a = 0; last_b = 0;
    end else if (ce) begin
      n_a++; n_b++;
      if (m_act(ca, n_a - 1)) last_a = m_addr(ca, n_a - 1);
      if (m_act(cb, n_b - 1)) last_b = m_addr(cb, n_b - 1);
    end
    exp_a = m_out(ca, n_a, last_a);
    exp_b = m_out(cb, n_b, last_b);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      if ({hsync_a, vsync_a, de_a, rd_a, addr_a, hsync_b, vsync_b, de_b, rd_b, addr_b} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0}) begin
        errors++;
        $display("FAIL reset_values cyc=%0d got_a=%h got_b=%h", cyc, got_a, got_b);
      end
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL reset_model cyc=%0d a=%h/%h b=%h/%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      checks++;
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 1200; i++) begin
      step(1'b1, 1'b0);
      if (got_a !== exp_a) begin
        errors++;
        $display("FAIL free_run_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_a);
      end
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL free_run_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_b);
      end
      checks++;
    end
  endtask

  task automatic test_ce_toggle();
    for (int i = 0; i < 1400; i++) begin
      if (i < 400) step(i[0] == 1'b0, 1'b0);
      else         step($urandom_range(0, 3) != 0, 1'b0);
      if (got_a !== exp_a) begin
        errors++;
        $display("FAIL ce_toggle_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_a);
      end
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL ce_toggle_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_b);
      end
      checks++;
    end
  endtask

  task automatic test_mid_reset();
    // Single-cycle reset deep inside a frame, then restart at the origin
    step(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    if ({de_a, rd_a, addr_a, ls_a, fs_a, de_b, rd_b, addr_b, x_b, y_b, hsync_b, vsync_b} !==
        {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 11'd0, 11'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_values cyc=%0d got_a=%h got_b=%h", cyc, got_a, got_b);
    end
    checks++;
    step(1'b1, 1'b0);
    if ({fs_b, ls_b, de_b, x_b, y_b, rd_b, addr_b} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 1'b1, 7'd0}) begin
      errors++;
      $display("FAIL mid_reset_restart cyc=%0d got=%h", cyc, got_b);
    end
    checks++;
    // Random resets mixed with random enables
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
      if (got_a !== exp_a) begin
        errors++;
        $display("FAIL rand_reset_a cyc=%0d got=%h exp=%h", cyc, got_a, exp_a);
      end
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL rand_reset_b cyc=%0d got=%h exp=%h", cyc, got_b, exp_b);
      end
      checks++;
    end
  endtask

  // Periods and widths counted in enabled cycles under a random enable
  task automatic test_periods();
    int e = 0;
    int fs_last_a = -1, fs_last_b = -1, ls_last_a = -1;
    int hs_run_a = 0, hs_run_b = 0, de_run_b = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 2400; i++) begin
      bit ce;
      ce = ($urandom_range(0, 2) != 0);
      step(ce, 1'b0);
      if (ce) begin
        e++;
        if (fs_b === 1'b1) begin
          if (fs_last_b >= 0) begin
            if (e - fs_last_b != 544) begin
              errors++;
              $display("FAIL frame_period_b got=%0d exp=544", e - fs_last_b);
            end
            checks++;
          end
          fs_last_b = e;
        end
        if (fs_a === 1'b1) begin
          if (fs_last_a >= 0) begin
            if (e - fs_last_a != 84) begin
              errors++;
              $display("FAIL frame_period_a got=%0d exp=84", e - fs_last_a);
            end
            checks++;
          end
          fs_last_a = e;
        end
        if (ls_a === 1'b1) begin
          if (ls_last_a >= 0) begin
            if (e - ls_last_a != 12) begin
              errors++;
              $display("FAIL line_period_a got=%0d exp=12", e - ls_last_a);
            end
            checks++;
          end
          ls_last_a = e;
        end
        if (hsync_b === 1'b1) hs_run_b++;
        else if (hs_run_b > 0) begin
          if (hs_run_b != 4) begin
            errors++;
            $display("FAIL hsync_width_b got=%0d exp=4", hs_run_b);
          end
          checks++;
          hs_run_b = 0;
        end
        if (hsync_a === 1'b0) hs_run_a++;
        else if (hs_run_a > 0) begin
          if (hs_run_a != 2) begin
            errors++;
            $display("FAIL hsync_width_a got=%0d exp=2", hs_run_a);
          end
          checks++;
          hs_run_a = 0;
        end
        if (de_b === 1'b1) de_run_b++;
        else if (de_run_b > 0) begin
          if (de_run_b != 20) begin
            errors++;
            $display("FAIL de_width_b got=%0d exp=20", de_run_b);
          end
          checks++;
          de_run_b = 0;
        end
      end
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL periods_model cyc=%0d a=%h/%h b=%h/%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      checks++;
    end
  endtask

  initial begin
    ca = '{ha: 8, hf: 1, hs: 2, hb: 1, va: 4, vf: 1, vs: 1, vb: 1,
           hpol: 0, vpol: 1, hsh: 1, vsh: 1, stride: 5, aw: 3, lat: 2};
    cb = '{ha: 20, hf: 3, hs: 4, hb: 5, va: 10, vf: 2, vs: 3, vb: 2,
           hpol: 1, vpol: 0, hsh: 0, vsh: 0, stride: 20, aw: 7, lat: 0};
    n_a = 0; n_b = 0; last_a = 0; last_b = 0;
    test_reset();
    test_free_run();
    test_ce_toggle();
    test_mid_reset();
    test_periods();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
